// File: rtl/dbus_io_pkg.sv
// rtl/dbus_io_pkg.sv - I/O window map, register offsets and STATUS layout for dbus_io_port
// Shared by dbus_io_port (optional stall counter: IO_STALL_CNT_EN).
package dbus_io_pkg;

  localparam logic [27:0] IO_WIN_TAG = 28'h00007FF;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;
  localparam logic [3:0] OFF_STALLS = 4'hC;
  localparam logic [3:0] OFF_HALT   = 4'hF;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_OCC_LSB = 4;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic ovf, input logic [3:0] occ);
    logic [31:0] w;
    w                   = '0;
    w[ST_FULL]          = full;
    w[ST_EMPTY]         = empty;
    w[ST_OVF]           = ovf;
    w[ST_OCC_LSB +: 4]  = occ;
    return w;
  endfunction

endpackage

// File: rtl/dbus_io_port_if.sv
// rtl/dbus_io_port_if.sv - core data-bus side and TX stream side of dbus_io_port
// master = core/sink driver, slave = the I/O port.
interface dbus_io_port_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        io_hit;
  logic [31:0] rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output addr, wdata, we, tx_ready,
                  input  io_hit, rdata, tx_data, tx_valid);
  modport slave  (input  addr, wdata, we, tx_ready,
                  output io_hit, rdata, tx_data, tx_valid);
endinterface

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous DEPTH x WIDTH FIFO, head word presented on rdata
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  // Memory is not reset, so an empty FIFO presents zero rather than stale data.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dbus_io_port.sv
// rtl/dbus_io_port.sv - memory-mapped I/O responder: TX FIFO, cycle/stall counters, halt latch
// Optional stall counter enabled by defining IO_STALL_CNT_EN.
module dbus_io_port #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  dbus_io_port_if.slave      bus,
  output logic               halted,
  output logic [31:0]        halt_code
);
  import dbus_io_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          hit, wr_en, push_req, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [4:0]    cnt_ext;
  logic [3:0]    occ;
  logic [3:0]    off;
  logic [31:0]   cycle_q, cycle_d, halt_code_q, halt_code_d, stalls_val;
  logic          ovf_q, ovf_d, halted_q, halted_d;

  assign off      = bus.addr[3:0];
  assign hit      = (bus.addr[31:4] == IO_WIN_TAG);
  assign wr_en    = bus.we & hit & ~halted_q;
  assign push_req = wr_en & (off == OFF_TXDATA);
  assign pop      = bus.tx_valid & bus.tx_ready;

  io_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (bus.wdata),
    .rdata (bus.tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_valid = ~fifo_empty;
  assign bus.io_hit   = hit;
  assign halted       = halted_q;
  assign halt_code    = halt_code_q;

  // Occupancy field is 4 bits; a 16-deep FIFO reports 15 when completely full.
  assign cnt_ext = 5'(fifo_count);
  assign occ     = (cnt_ext > 5'd15) ? 4'hF : cnt_ext[3:0];

`ifdef IO_STALL_CNT_EN
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    stalls_d = stalls_q;
    if (!halted_q && stall_in) stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stalls_q <= '0;
    else     stalls_q <= stalls_d;
  end

  assign stalls_val = stalls_q;
`else
  logic unused_stall_in;
  assign unused_stall_in = stall_in;
  assign stalls_val      = '0;
`endif

  always_comb begin
    cycle_d     = cycle_q;
    ovf_d       = ovf_q;
    halted_d    = halted_q;
    halt_code_d = halt_code_q;
    if (!halted_q) begin
      cycle_d = (wr_en && off == OFF_CYCLE) ? 32'd0 : cycle_q + 32'd1;
      if (push_req && fifo_full && !pop) ovf_d = 1'b1;
      if (wr_en && off == OFF_STATUS && bus.wdata[ST_OVF]) ovf_d = 1'b0;
      if (wr_en && off == OFF_HALT) begin
        halted_d    = 1'b1;
        halt_code_d = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      ovf_q       <= 1'b0;
      halted_q    <= 1'b0;
      halt_code_q <= '0;
    end else begin
      cycle_q     <= cycle_d;
      ovf_q       <= ovf_d;
      halted_q    <= halted_d;
      halt_code_q <= halt_code_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: bus.rdata = status_word(fifo_full, fifo_empty, ovf_q, occ);
        OFF_CYCLE:  bus.rdata = cycle_q;
        OFF_STALLS: bus.rdata = stalls_val;
        default:    bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_io_port.sv
// tb/tb_dbus_io_port.sv - self-checking bench for dbus_io_port (honours IO_STALL_CNT_EN)
module tb_dbus_io_port;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        halted;
  logic [31:0] halt_code;

  dbus_io_port_if bus();

  dbus_io_port #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_in  (stall_in),
    .bus       (bus),
    .halted    (halted),
    .halt_code (halt_code)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ovf, m_halted;
  logic [31:0] m_cycle, m_stalls, m_code;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rdy;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic        exp_valid;
    logic [31:0] exp_txd;
  } vec_t;

  vec_t vt[13];
  logic [31:0] got[$];
  logic [31:0] exp_drain[4];
  logic [31:0] cyc0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= 32'h7FF0) && (a <= 32'h7FFF);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    int sz;
    sz = mq.size();
    if (!in_window(a)) return 32'h0;
    case (a)
      32'h7FF4: return 32'((sz == DEPTH) ? 1 : 0) + 32'((sz == 0) ? 2 : 0)
                     + 32'(m_ovf ? 4 : 0) + 32'(sz * 16);
      32'h7FF8: return m_cycle;
`ifdef IO_STALL_CNT_EN
      32'h7FFC: return m_stalls;
`endif
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_halted = 0;
    m_cycle = 0; m_stalls = 0; m_code = 0;
  endtask

  task automatic model_update(input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic s, input logic rdy);
    bit wr;
    if (r) begin
      model_reset();
      return;
    end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (m_halted) return;
    wr = w && in_window(a);
    m_cycle = (wr && a == 32'h7FF8) ? 32'h0 : m_cycle + 32'h1;
    if (s) m_stalls = m_stalls + 32'h1;
    if (wr && a == 32'h7FF0) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
    end
    if (wr && a == 32'h7FF4 && d[2]) m_ovf = 0;
    if (wr && a == 32'h7FFF) begin
      m_halted = 1;
      m_code   = d;
    end
  endtask

  task automatic model_compare();
    check("io_hit", 32'(bus.io_hit), 32'(in_window(bus.addr)));
    check("rdata", bus.rdata, m_rd(bus.addr));
    check("tx_valid", 32'(bus.tx_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) check("tx_data", bus.tx_data, mq[0]);
    check("halted", 32'(halted), 32'(m_halted));
    check("halt_code", halt_code, m_code);
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic s, input logic rdy);
    bus.addr = a; bus.wdata = d; bus.we = w; stall_in = s; bus.tx_ready = rdy;
  endtask

  task automatic step();
    #1;
    model_compare();
    model_update(rst, bus.addr, bus.wdata, bus.we, stall_in, bus.tx_ready);
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    check("reset_tx_data", bus.tx_data, 32'h0);

    //        addr          wdata   we  rdy  exp_rdata  hit valid txd
    vt[0]  = '{32'h7FF4, 32'h0, 1'b0, 1'b0, 32'h02, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{32'h1000, 32'h0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{32'h7FF0, 32'hA, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h0};
    vt[3]  = '{32'h7FF0, 32'hB, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA};
    vt[4]  = '{32'h7FF0, 32'hC, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA};
    vt[5]  = '{32'h7FF4, 32'h0, 1'b0, 1'b0, 32'h30, 1'b1, 1'b1, 32'hA};
    vt[6]  = '{32'h7FF0, 32'hD, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA};
    vt[7]  = '{32'h7FF0, 32'hE, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA};
    vt[8]  = '{32'h7FF4, 32'h0, 1'b0, 1'b0, 32'h45, 1'b1, 1'b1, 32'hA};
    vt[9]  = '{32'h7FF4, 32'h4, 1'b1, 1'b0, 32'h45, 1'b1, 1'b1, 32'hA};
    vt[10] = '{32'h7FF4, 32'h0, 1'b0, 1'b0, 32'h41, 1'b1, 1'b1, 32'hA};
    vt[11] = '{32'h7FF0, 32'hF, 1'b1, 1'b1, 32'h00, 1'b1, 1'b1, 32'hA};
    vt[12] = '{32'h7FF4, 32'h0, 1'b0, 1'b0, 32'h41, 1'b1, 1'b1, 32'hB};

    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].addr, vt[i].wdata, vt[i].we, 1'b0, vt[i].rdy);
      #1;
      check($sformatf("vec%0d_hit", i), 32'(bus.io_hit), 32'(vt[i].exp_hit));
      check($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d_valid", i), 32'(bus.tx_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) check($sformatf("vec%0d_txd", i), bus.tx_data, vt[i].exp_txd);
      step();
    end

    // Drain: B,C,D were kept, E was dropped, F entered on the full+pop cycle
    exp_drain = '{32'hB, 32'hC, 32'hD, 32'hF};
    set_in(32'h7FF4, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      #1;
      if (bus.tx_valid) got.push_back(bus.tx_data);
      step();
    end
    check("drain_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain%0d", i), (i < got.size()) ? got[i] : 32'hDEADDEAD, exp_drain[i]);
    #1;
    check("drain_status", bus.rdata, 32'h2);

    // Cycle counter clear then ten idle cycles
    set_in(32'h7FF8, 32'h1234, 1'b1, 1'b0, 1'b0);
    step();
    set_in(32'h7FF8, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("cycle_after_clear", bus.rdata, 32'd0);
    repeat (10) step();
    #1;
    check("cycle_10", bus.rdata, 32'd10);

    set_in(32'h7FFC, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    set_in(32'h7FFC, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef IO_STALL_CNT_EN
    check("stalls_3", bus.rdata, 32'd3);
`else
    check("stalls_off", bus.rdata, 32'd0);
`endif

    // Halt with two words queued, then reset mid-drain
    set_in(32'h7FF0, 32'h11, 1'b1, 1'b0, 1'b0); step();
    set_in(32'h7FF0, 32'h22, 1'b1, 1'b0, 1'b0); step();
    set_in(32'h7FFF, 32'h600D, 1'b1, 1'b0, 1'b0); step();
    set_in(32'h7FF8, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("halted", 32'(halted), 32'd1);
    check("halt_code", halt_code, 32'h600D);
    cyc0 = bus.rdata;
    step();
    set_in(32'h7FFF, 32'hBAD, 1'b1, 1'b0, 1'b0); step();
    set_in(32'h7FF0, 32'h33, 1'b1, 1'b0, 1'b1); step();
    set_in(32'h7FF8, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("halt_code_kept", halt_code, 32'h600D);
    check("cycle_frozen", bus.rdata, cyc0);
    check("drain_after_halt", bus.tx_data, 32'h22);
    rst = 1'b1; step(); step(); rst = 1'b0;
    set_in(32'h7FF4, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_status", bus.rdata, 32'h2);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_code", halt_code, 32'd0);
    check("rst_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", bus.tx_data, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0, 1, 8: a = 32'h7FF0;
        2:       a = 32'h7FF4;
        3:       a = 32'h7FF8;
        4:       a = 32'h7FFC;
        5:       a = 32'h7FF0 + 32'($urandom_range(0, 15));
        6:       a = $urandom;
        7:       a = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h00017FF0;
        default: a = ($urandom_range(0, 49) == 0) ? 32'h7FFF : 32'h7FF4;
      endcase
      set_in(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 399) == 0);
      step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
